sad_phase_matcher: RTL and testbench

Parametrised successor to the waveform-memory matching pass. It sweeps a phase offset across two waveform regions held in the external SRAM. For each phase it accumulates the sum of absolute differences (SAD), tracks the minimum SAD and its phase, and flags a match against a threshold. It sits between the command decoder (START/THRESH) and the SRAM address/data bus, and owns the bus only while BUSY.

---
 rtl/sad_phase_matcher.sv | 205 ++++++++++++++++++++
 tb/tb_sad_phase_matcher.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/sad_phase_matcher.sv
// sad_phase_matcher: sweeps a phase offset between a capture region and a
// reference region in external SRAM, accumulates a saturating sum of absolute
// differences per phase and keeps the earliest minimum.
// Build macro SAD_RESULT_WR_EN: when defined, each phase's SAD (saturated to
// 16 bits) is written to BASE_R + phase. When undefined, that write state is
// never entered and the write bus stays at 0.
//
// state | meaning
// IDLE  | bus released, waiting for START
// RDA   | drive capture-region address for sample i
// RDB   | drive reference-region address, index (i+p) mod LEN
// WAIT  | hold until both read words have been captured
// ACC   | add |A-B| into the saturating per-phase sum
// WRES  | write the phase result (SAD_RESULT_WR_EN builds only)
// NEXT  | fold the sum into the best result, advance the phase
// FIN   | one-cycle DONE, resolve MATCH
module sad_phase_matcher #(
  parameter int DW     = 10,
  parameter int AW     = 20,
  parameter int LEN    = 8192,
  parameter int NPHASE = 1501,
  parameter int SAD_W  = 24,
  parameter int BASE_A = 0,
  parameter int BASE_B = 8192,
  parameter int BASE_R = 16384,
  parameter int RD_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [SAD_W-1:0]  THRESH,
  output logic              BUSY,
  output logic              DONE,
  output logic              MATCH,
  output logic [15:0]       BEST_PHASE,
  output logic [SAD_W-1:0]  BEST_SAD,
  output logic [AW-1:0]     MEM_ADR,
  output logic              MEM_OE,
  output logic              MEM_WE,
  output logic [15:0]       MEM_WDATA,
  input  logic [15:0]       MEM_RDATA
);

  localparam int LW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int CW = $clog2(RD_LAT + 2);
  localparam int EW = ((SAD_W > DW) ? SAD_W : DW) + 1;
  localparam logic [SAD_W-1:0] SAD_MAX = {SAD_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE, S_RDA, S_RDB, S_WAIT, S_ACC, S_WRES, S_NEXT, S_FIN
  } state_t;

  state_t             state, state_nxt;
  logic [LW-1:0]      i, b_idx;
  logic [15:0]        p;
  logic [SAD_W-1:0]   sum, sum_acc, thresh_q;
  logic [DW-1:0]      a_q, b_q, diff;
  logic [EW-1:0]      acc_ext;
  logic [CW-1:0]      cnt;
  logic               match_q;
  logic               last_i, last_p;
  logic               unused_rdata;

  assign unused_rdata = ^MEM_RDATA[15:DW];
  assign b_idx  = i + p[LW-1:0];
  assign last_i = (i == LW'(LEN - 1));
  assign last_p = (p == 16'(NPHASE - 1));

  // Absolute difference of the captured samples and saturating accumulate.
  always_comb begin
    diff    = (a_q > b_q) ? (a_q - b_q) : (b_q - a_q);
    acc_ext = EW'(sum) + EW'(diff);
    sum_acc = (acc_ext > EW'(SAD_MAX)) ? SAD_MAX : acc_ext[SAD_W-1:0];
  end

`ifdef SAD_RESULT_WR_EN
  localparam int WW = (SAD_W > 16) ? SAD_W : 16;
  logic [WW-1:0] sum_w;
  logic [15:0]   wdata_sat;
  assign sum_w     = WW'(sum);
  assign wdata_sat = (sum_w > WW'(16'hFFFF)) ? 16'hFFFF : sum_w[15:0];
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and bus/status outputs; the bus is only driven while busy.
  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    MATCH     = match_q;
    MEM_ADR   = '0;
    MEM_OE    = 1'b0;
    MEM_WE    = 1'b0;
    MEM_WDATA = '0;
    case (state)
      S_IDLE: if (START) state_nxt = S_RDA;
      S_RDA: begin
        BUSY      = 1'b1;
        MEM_OE    = 1'b1;
        MEM_ADR   = AW'(BASE_A) + AW'(i);
        state_nxt = S_RDB;
      end
      S_RDB: begin
        BUSY      = 1'b1;
        MEM_OE    = 1'b1;
        MEM_ADR   = AW'(BASE_B) + AW'(b_idx);
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        BUSY = 1'b1;
        if (cnt == '0) state_nxt = S_ACC;
      end
      S_ACC: begin
        BUSY = 1'b1;
        if (last_i) begin
`ifdef SAD_RESULT_WR_EN
          state_nxt = S_WRES;
`else
          state_nxt = S_NEXT;
`endif
        end else begin
          state_nxt = S_RDA;
        end
      end
      S_WRES: begin
`ifdef SAD_RESULT_WR_EN
        BUSY      = 1'b1;
        MEM_WE    = 1'b1;
        MEM_ADR   = AW'(BASE_R) + AW'(p);
        MEM_WDATA = wdata_sat;
        state_nxt = S_NEXT;
`else
        state_nxt = S_IDLE;
`endif
      end
      S_NEXT: begin
        BUSY      = 1'b1;
        state_nxt = last_p ? S_FIN : S_RDA;
      end
      S_FIN: begin
        DONE      = 1'b1;
        MATCH     = (BEST_SAD < thresh_q);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: indices, read-capture timer, per-phase sum and best tracking.
  // cnt runs RD_LAT..0 from the cycle after RDA, so A lands at cnt==1
  // and B at cnt==0, matching the fixed SRAM read latency.
  always_ff @(posedge CLK) begin
    if (RST) begin
      i          <= '0;
      p          <= '0;
      sum        <= '0;
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      thresh_q   <= '0;
      BEST_SAD   <= SAD_MAX;
      BEST_PHASE <= '0;
      match_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (START) begin
          thresh_q   <= THRESH;
          i          <= '0;
          p          <= '0;
          sum        <= '0;
          BEST_SAD   <= SAD_MAX;
          BEST_PHASE <= '0;
          match_q    <= 1'b0;
        end
        S_RDA: cnt <= CW'(RD_LAT);
        S_RDB, S_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) a_q <= MEM_RDATA[DW-1:0];
          if (cnt == '0)     b_q <= MEM_RDATA[DW-1:0];
        end
        S_ACC: begin
          sum <= sum_acc;
          i   <= i + LW'(1);
        end
        S_NEXT: begin
          if (sum < BEST_SAD) begin
            BEST_SAD   <= sum;
            BEST_PHASE <= p;
          end
          sum <= '0;
          i   <= '0;
          if (!last_p) p <= p + 16'd1;
        end
        S_FIN: match_q <= (BEST_SAD < thresh_q);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_phase_matcher.sv
// Bench for sad_phase_matcher: small geometry (LEN=4, NPHASE=3, RD_LAT=2,
// SAD_W=8) against a behavioural SRAM with fixed read latency. Expected SAD,
// best phase, match and DONE timing come from a direct per-phase model.
module tb_sad_phase_matcher;
  localparam int DW = 10, AW = 8, LEN = 4, NPHASE = 3, SAD_W = 8;
  localparam int BASE_A = 0, BASE_B = 16, BASE_R = 32, RD_LAT = 2;
`ifdef SAD_RESULT_WR_EN
  localparam int WR = 1;
`else
  localparam int WR = 0;
`endif
  localparam int DONE_AT = NPHASE * (LEN * (RD_LAT + 3) + WR + 1) + 1;
  localparam logic [15:0] RES_FILL = 16'hAAAA;

  logic              CLK, RST, START, BUSY, DONE, MATCH, MEM_OE, MEM_WE;
  logic [SAD_W-1:0]  THRESH, BEST_SAD;
  logic [15:0]       BEST_PHASE, MEM_WDATA, MEM_RDATA;
  logic [AW-1:0]     MEM_ADR;

  int checks = 0, failures = 0, viol = 0;

  logic [15:0]   mem [0:255];
  logic [AW-1:0] apipe [0:RD_LAT-1];
  logic          ld_en;
  logic [AW-1:0] ld_adr;
  logic [15:0]   ld_dat;

  logic [15:0] a_v [0:LEN-1];
  logic [15:0] b_v [0:LEN-1];
  int exp_sad [0:NPHASE-1];
  int exp_best, exp_phase;

  int r_done_cyc, r_done_cnt, r_oe, r_we;
  logic r_busy1, r_busy_done, r_match_done, r_match_after;
  logic [15:0] r_phase;
  logic [SAD_W-1:0] r_sad;

  sad_phase_matcher #(
    .DW(DW), .AW(AW), .LEN(LEN), .NPHASE(NPHASE), .SAD_W(SAD_W),
    .BASE_A(BASE_A), .BASE_B(BASE_B), .BASE_R(BASE_R), .RD_LAT(RD_LAT)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .THRESH(THRESH), .BUSY(BUSY),
    .DONE(DONE), .MATCH(MATCH), .BEST_PHASE(BEST_PHASE), .BEST_SAD(BEST_SAD),
    .MEM_ADR(MEM_ADR), .MEM_OE(MEM_OE), .MEM_WE(MEM_WE),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // SRAM: data reflects the address presented RD_LAT cycles earlier.
  always @(posedge CLK) begin
    apipe[0] <= MEM_ADR;
    for (int k = 1; k < RD_LAT; k++) apipe[k] <= apipe[k-1];
    if (ld_en) mem[ld_adr] <= ld_dat;
    else if (MEM_WE) mem[MEM_ADR] <= MEM_WDATA;
  end
  assign MEM_RDATA = mem[apipe[RD_LAT-1]];

  // Bus rules: never read and write together, bus idle when not busy.
  always @(negedge CLK) begin
    if (!RST) begin
      if (MEM_OE && MEM_WE) viol++;
      if (!BUSY && (MEM_OE || MEM_WE || MEM_ADR != '0)) viol++;
    end
  end

  task automatic load_mem();
    for (int k = 0; k < LEN; k++) begin
      ld_en = 1'b1; ld_adr = AW'(BASE_A + k); ld_dat = a_v[k]; @(negedge CLK);
      ld_adr = AW'(BASE_B + k); ld_dat = b_v[k]; @(negedge CLK);
    end
    for (int k = 0; k < NPHASE; k++) begin
      ld_adr = AW'(BASE_R + k); ld_dat = RES_FILL; @(negedge CLK);
    end
    ld_en = 1'b0;
  endtask

  task automatic compute_model();
    int s, da, db, maxv;
    maxv = (1 << SAD_W) - 1;
    for (int ph = 0; ph < NPHASE; ph++) begin
      s = 0;
      for (int k = 0; k < LEN; k++) begin
        da = int'(a_v[k][DW-1:0]);
        db = int'(b_v[(k + ph) % LEN][DW-1:0]);
        s = s + ((da > db) ? da - db : db - da);
        if (s > maxv) s = maxv;
      end
      exp_sad[ph] = s;
    end
    exp_best = maxv; exp_phase = 0;
    for (int ph = 0; ph < NPHASE; ph++)
      if (exp_sad[ph] < exp_best) begin exp_best = exp_sad[ph]; exp_phase = ph; end
  endtask

  // One run from a negedge: START for one cycle, observe until well after DONE.
  task automatic run_case(input int thr, input int start2_at, input int thr2);
    r_done_cyc = -1; r_done_cnt = 0; r_oe = 0; r_we = 0;
    START = 1'b1; THRESH = SAD_W'(thr);
    for (int c = 1; c <= DONE_AT + 4; c++) begin
      @(negedge CLK);
      if (c == 1) r_busy1 = BUSY;
      if (MEM_OE) r_oe++;
      if (MEM_WE) r_we++;
      if (DONE) begin
        r_done_cnt++;
        if (r_done_cyc < 0) begin
          r_done_cyc = c; r_busy_done = BUSY; r_match_done = MATCH;
          r_phase = BEST_PHASE; r_sad = BEST_SAD;
        end
      end
      if (c == 1) START = 1'b0;
      if (c == start2_at) begin START = 1'b1; THRESH = SAD_W'(thr2); end
      else if (c == start2_at + 1) START = 1'b0;
    end
    r_match_after = MATCH;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", DONE); end
    checks++; if (MATCH !== 1'b0) begin failures++; $display("FAIL reset_match got %b exp 0", MATCH); end
    checks++; if (BEST_PHASE !== 16'd0) begin failures++; $display("FAIL reset_best_phase got %0d exp 0", BEST_PHASE); end
    checks++; if (BEST_SAD !== 8'hFF) begin failures++; $display("FAIL reset_best_sad got %0d exp 255", BEST_SAD); end
    checks++; if (MEM_ADR !== '0) begin failures++; $display("FAIL reset_mem_adr got %0d exp 0", MEM_ADR); end
    checks++; if (MEM_OE !== 1'b0 || MEM_WE !== 1'b0) begin failures++; $display("FAIL reset_oe_we got %b%b exp 00", MEM_OE, MEM_WE); end
    checks++; if (MEM_WDATA !== 16'd0) begin failures++; $display("FAIL reset_wdata got %0d exp 0", MEM_WDATA); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_pattern(input string name, input int thr);
    load_mem();
    compute_model();
    run_case(thr, -10, 0);
    checks++; if (r_done_cyc != DONE_AT) begin failures++; $display("FAIL %s done_cycle got %0d exp %0d", name, r_done_cyc, DONE_AT); end
    checks++; if (r_done_cnt != 1) begin failures++; $display("FAIL %s done_pulses got %0d exp 1", name, r_done_cnt); end
    checks++; if (r_busy1 !== 1'b1) begin failures++; $display("FAIL %s busy_rise got %b exp 1", name, r_busy1); end
    checks++; if (r_busy_done !== 1'b0) begin failures++; $display("FAIL %s busy_at_done got %b exp 0", name, r_busy_done); end
    checks++; if (r_phase !== 16'(exp_phase)) begin failures++; $display("FAIL %s best_phase got %0d exp %0d", name, r_phase, exp_phase); end
    checks++; if (r_sad !== SAD_W'(exp_best)) begin failures++; $display("FAIL %s best_sad got %0d exp %0d", name, r_sad, exp_best); end
    checks++; if (r_match_done !== (exp_best < thr)) begin failures++; $display("FAIL %s match_at_done got %b exp %b", name, r_match_done, exp_best < thr); end
    checks++; if (r_match_after !== (exp_best < thr)) begin failures++; $display("FAIL %s match_hold got %b exp %b", name, r_match_after, exp_best < thr); end
    checks++; if (r_oe != NPHASE * LEN * 2) begin failures++; $display("FAIL %s read_cycles got %0d exp %0d", name, r_oe, NPHASE * LEN * 2); end
    checks++; if (r_we != NPHASE * WR) begin failures++; $display("FAIL %s write_cycles got %0d exp %0d", name, r_we, NPHASE * WR); end
    for (int ph = 0; ph < NPHASE; ph++) begin
      checks++;
      if (mem[BASE_R + ph] !== ((WR == 1) ? 16'(exp_sad[ph]) : RES_FILL)) begin
        failures++;
        $display("FAIL %s result_word[%0d] got %0d exp %0d", name, ph, mem[BASE_R + ph],
                 (WR == 1) ? exp_sad[ph] : int'(RES_FILL));
      end
    end
  endtask

  task automatic set_ab(input int a0, a1, a2, a3, b0, b1, b2, b3);
    a_v[0] = 16'(a0); a_v[1] = 16'(a1); a_v[2] = 16'(a2); a_v[3] = 16'(a3);
    b_v[0] = 16'(b0); b_v[1] = 16'(b1); b_v[2] = 16'(b2); b_v[3] = 16'(b3);
  endtask

  task automatic test_reset_midrun();
    set_ab(10, 20, 30, 40, 10, 20, 30, 40);
    load_mem();
    START = 1'b1; THRESH = 8'd1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      if (c == 1) START = 1'b0;
    end
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL midrun_rst_busy got %b exp 0", BUSY); end
    checks++; if (MEM_OE !== 1'b0) begin failures++; $display("FAIL midrun_rst_oe got %b exp 0", MEM_OE); end
    checks++; if (BEST_SAD !== 8'hFF) begin failures++; $display("FAIL midrun_rst_best_sad got %0d exp 255", BEST_SAD); end
    checks++; if (BEST_PHASE !== 16'd0 || MATCH !== 1'b0) begin failures++; $display("FAIL midrun_rst_phase_match got %0d/%b exp 0/0", BEST_PHASE, MATCH); end
    RST = 1'b0;
    @(negedge CLK);
    test_pattern("after_reset", 1);
  endtask

  task automatic test_back_to_back();
    set_ab(10, 20, 30, 40, 10, 20, 30, 40);
    load_mem();
    compute_model();
    run_case(1, 10, 0);
    checks++; if (r_done_cnt != 1) begin failures++; $display("FAIL ignored_start done_pulses got %0d exp 1", r_done_cnt); end
    checks++; if (r_done_cyc != DONE_AT) begin failures++; $display("FAIL ignored_start done_cycle got %0d exp %0d", r_done_cyc, DONE_AT); end
    checks++; if (r_match_done !== (exp_best < 1)) begin failures++; $display("FAIL ignored_start match got %b exp %b", r_match_done, exp_best < 1); end
    checks++; if (r_sad !== SAD_W'(exp_best)) begin failures++; $display("FAIL ignored_start best_sad got %0d exp %0d", r_sad, exp_best); end
  endtask

  task automatic test_random();
    int rot;
    for (int n = 0; n < 4; n++) begin
      rot = int'($urandom_range(0, LEN - 1));
      for (int k = 0; k < LEN; k++)
        a_v[k] = 16'($urandom_range(0, 63)) | 16'($urandom_range(0, 63) << DW);
      for (int k = 0; k < LEN; k++) begin
        if (n[0]) b_v[(k + rot) % LEN] = {6'($urandom_range(0, 63)), a_v[k][DW-1:0]};
        else      b_v[k] = 16'($urandom_range(0, 63)) | 16'($urandom_range(0, 63) << DW);
      end
      test_pattern("random", int'($urandom_range(0, 255)));
    end
  endtask

  task automatic test_bus_rules();
    checks++;
    if (viol != 0) begin failures++; $display("FAIL bus_rules violations got %0d exp 0", viol); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; START = 1'b0; THRESH = '0; ld_en = 1'b0; ld_adr = '0; ld_dat = '0;
    test_reset();
    set_ab(10, 20, 30, 40, 10, 20, 30, 40);        test_pattern("identical", 1);
    set_ab(10, 20, 30, 40, 30, 40, 10, 20);        test_pattern("rotated", 5);
    set_ab(0, 0, 0, 0, 5, 5, 5, 5);                test_pattern("tie", 20);
    set_ab(1023, 1023, 1023, 1023, 0, 0, 0, 0);    test_pattern("saturate", 255);
    test_reset_midrun();
    test_back_to_back();
    test_random();
    test_bus_rules();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
